// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - widths, FSM state type and the 16-bit saturation helper for eq_band_sched
package eq_pkg;

  localparam int BAND_W = 16;
  localparam int POT_W  = 12;
  localparam int GAIN_W = 13;
  localparam int PROD_W = 29;
  localparam int ACC_W  = 19;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // Any 19-bit signed value clipped into the signed 16-bit range.
  function automatic logic [BAND_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    logic [BAND_W-1:0] r;
    if (v > 19'sd32767)
      r = 16'h7FFF;
    else if (v < -19'sd32768)
      r = 16'h8000;
    else
      r = v[BAND_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/band_scale_pipe.sv
// rtl/band_scale_pipe.sv - two-stage square-law band scaler, audio * (pot^2 >> 12) >> 10, saturated
module band_scale_pipe
  import eq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [BAND_W-1:0] audio,
  input  logic        [POT_W-1:0]  pot,
  output logic                     out_valid,
  output logic signed [BAND_W-1:0] scaled
);

  logic        [2*POT_W-1:0] sq;
  logic                      s1_valid;
  logic signed [BAND_W-1:0]  s1_audio;
  logic signed [GAIN_W-1:0]  s1_gain;
  logic signed [PROD_W-1:0]  prod;

  assign sq   = {{POT_W{1'b0}}, pot} * {{POT_W{1'b0}}, pot};
  assign prod = PROD_W'(s1_audio) * PROD_W'(s1_gain);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
    end
  end

  // prod[28:10] fits 16 bits exactly when prod[28:25] agree, so sat16 covers the clip rule.
  always_ff @(posedge clk) begin
    s1_audio <= audio;
    s1_gain  <= {1'b0, sq[2*POT_W-1:POT_W]};
    scaled   <= sat16(prod[PROD_W-1:10]);
  end

endmodule

// File: rtl/eq_band_sched.sv
// rtl/eq_band_sched.sv - snapshots all bands, scales them one per cycle through a shared pipe, sums and clips
module eq_band_sched
  import eq_pkg::*;
#(
  parameter int NUM_BANDS = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          smpl_valid,
  input  logic [BAND_W*NUM_BANDS-1:0]   band_audio,
  input  logic [POT_W*NUM_BANDS-1:0]    band_pot,
  input  logic                          ovr_clr,
  output logic [BAND_W-1:0]             eq_out,
  output logic                          eq_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_BANDS - 1);

  state_t                     state;
  logic [2:0]                 idx;
  logic                       drain_cnt;
  logic signed [BAND_W-1:0]   aud_q [NUM_BANDS];
  logic        [POT_W-1:0]    pot_q [NUM_BANDS];
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_next;
  logic                       accepting;
  logic                       issue_valid;
  logic                       sc_valid;
  logic signed [BAND_W-1:0]   sc;

  assign accepting   = (state == IDLE) || (state == DONE);
  assign issue_valid = (state == ISSUE);

  band_scale_pipe u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issue_valid),
    .audio     (aud_q[idx]),
    .pot       (pot_q[idx]),
    .out_valid (sc_valid),
    .scaled    (sc)
  );

  always_comb begin
    acc_next = acc;
    if (sc_valid)
      acc_next = acc + $signed({{(ACC_W-BAND_W){sc[BAND_W-1]}}, sc});
  end

  always_ff @(posedge clk) begin
    if (accepting && smpl_valid) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        aud_q[i] <= band_audio[BAND_W*i +: BAND_W];
        pot_q[i] <= band_pot[POT_W*i +: POT_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      drain_cnt <= 1'b0;
      acc       <= '0;
      eq_out    <= '0;
      eq_valid  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      eq_valid <= 1'b0;
      acc      <= acc_next;
      // A strobe while busy is dropped; flagging it beats a simultaneous clear.
      if (smpl_valid && busy)
        overrun <= 1'b1;
      else if (ovr_clr)
        overrun <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (smpl_valid) begin
            acc   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          idx <= idx + 3'd1;
          if (idx == LAST_IDX) begin
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            eq_out   <= sat16(acc_next);
            eq_valid <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_band_sched.sv
// tb/tb_eq_band_sched.sv - randomized self-checking bench for eq_band_sched against an integer model
module tb_eq_band_sched;

  localparam int NB  = 5;
  localparam int LAT = NB + 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              smpl_valid;
  logic [16*NB-1:0]  band_audio;
  logic [12*NB-1:0]  band_pot;
  logic              ovr_clr;
  logic [15:0]       eq_out;
  logic              eq_valid;
  logic              busy;
  logic              overrun;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int m_aud [NB];
  int m_pot [NB];

  eq_band_sched #(.NUM_BANDS(NB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .smpl_valid (smpl_valid),
    .band_audio (band_audio),
    .band_pot   (band_pot),
    .ovr_clr    (ovr_clr),
    .eq_out     (eq_out),
    .eq_valid   (eq_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  function automatic longint clip16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Gain is pot^2/4096 (floored), band result is floor(audio*gain/1024) clipped, sum clipped.
  function automatic int ref_eq();
    longint s = 0;
    for (int b = 0; b < NB; b++) begin
      longint g = (longint'(m_pot[b]) * longint'(m_pot[b])) / 4096;
      longint p = longint'(m_aud[b]) * g;
      longint q = p / 1024;
      if (p < 0 && (q * 1024) != p) q = q - 1;
      s += clip16(q);
    end
    return int'(clip16(s));
  endfunction

  function automatic int pick_audio();
    case ($urandom_range(0, 3))
      0:       return 32767;
      1:       return -32768;
      default: return int'($signed(16'($urandom)));
    endcase
  endfunction

  function automatic int pick_pot();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return 4095;
      default: return int'($urandom_range(0, 4095));
    endcase
  endfunction

  task automatic set_all(input int a, input int p);
    for (int b = 0; b < NB; b++) begin
      m_aud[b] = a;
      m_pot[b] = p;
    end
  endtask

  task automatic apply_strobe();
    for (int b = 0; b < NB; b++) begin
      band_audio[16*b +: 16] = 16'(m_aud[b]);
      band_pot[12*b +: 12]   = 12'(m_pot[b]);
    end
    smpl_valid = 1'b1;
  endtask

  // Called at the strobe negedge; returns the cycle offset of eq_valid (0 if never seen).
  task automatic wait_result(output int lat);
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        smpl_valid = 1'b0;
        band_audio = {NB{16'($urandom)}};
        band_pot   = {NB{12'($urandom)}};
      end
      if (eq_valid) lat = c;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (eq_out !== 16'h0) $display("FAIL reset_eq_out got %h want 0000", eq_out); else pass_cnt++;
    total_cnt++; if (eq_valid !== 1'b0) $display("FAIL reset_eq_valid got %b want 0", eq_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_band();
    int exp_v;
    set_all(0, $urandom_range(0, 4095));
    m_aud[0] = 16'h1000;
    m_pot[0] = 4095;
    exp_v = ref_eq();
    apply_strobe();
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      if (c == 1) smpl_valid = 1'b0;
      total_cnt++;
      if (busy !== (c < LAT)) $display("FAIL single_busy_c%0d got %b want %b", c, busy, (c < LAT));
      else pass_cnt++;
      total_cnt++;
      if (eq_valid !== (c == LAT)) $display("FAIL single_eq_valid_c%0d got %b want %b", c, eq_valid, (c == LAT));
      else pass_cnt++;
    end
    total_cnt++; if (eq_out !== 16'h3FF8) $display("FAIL single_eq_out got %h want 3ff8", eq_out); else pass_cnt++;
    total_cnt++; if (eq_out !== 16'(exp_v)) $display("FAIL single_model got %h want %h", eq_out, 16'(exp_v)); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (eq_valid !== 1'b0) $display("FAIL single_pulse_width got %b want 0", eq_valid); else pass_cnt++;
  endtask

  task automatic test_patterns();
    int lat;
    int a_tab [6] = '{1000, -1000, 32767, -32768, 12345, -7};
    int p_tab [6] = '{2048, 2048, 4095, 4095, 0, 0};
    int f_tab [6] = '{5000, -5000, 32767, -32768, 0, 0};
    for (int t = 0; t < 6; t++) begin
      set_all(a_tab[t], p_tab[t]);
      if (ref_eq() != f_tab[t]) $display("note: model disagrees with table for pattern %0d", t);
      apply_strobe();
      wait_result(lat);
      total_cnt++;
      if (lat !== LAT) $display("FAIL pattern%0d_latency got %0d want %0d", t, lat, LAT); else pass_cnt++;
      total_cnt++;
      if (eq_out !== 16'(f_tab[t])) $display("FAIL pattern%0d_eq_out got %h want %h", t, eq_out, 16'(f_tab[t]));
      else pass_cnt++;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_overrun();
    int lat;
    set_all(1000, 2048);
    apply_strobe();
    @(negedge clk); smpl_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); set_all(-1000, 4095); apply_strobe();
    @(negedge clk); smpl_valid = 1'b0; ovr_clr = 1'b1;
    total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_set got %b want 1", overrun); else pass_cnt++;
    @(negedge clk); ovr_clr = 1'b0;
    total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_clear got %b want 0", overrun); else pass_cnt++;
    @(negedge clk); smpl_valid = 1'b1; ovr_clr = 1'b1;
    @(negedge clk); smpl_valid = 1'b0; ovr_clr = 1'b0;
    total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_set_wins got %b want 1", overrun); else pass_cnt++;
    ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    total_cnt++; if (eq_valid !== 1'b1) $display("FAIL ovr_first_valid got %b want 1", eq_valid); else pass_cnt++;
    total_cnt++; if (eq_out !== 16'd5000) $display("FAIL ovr_first_out got %h want 1388", eq_out); else pass_cnt++;
    set_all(-1000, 2048);
    apply_strobe();
    wait_result(lat);
    total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_done_strobe got %b want 0", overrun); else pass_cnt++;
    total_cnt++; if (lat !== LAT) $display("FAIL ovr_second_latency got %0d want %0d", lat, LAT); else pass_cnt++;
    total_cnt++; if (eq_out !== 16'hEC78) $display("FAIL ovr_second_out got %h want ec78", eq_out); else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen = 0;
    int exp_v;
    set_all(1000, 2048);
    apply_strobe();
    @(negedge clk); smpl_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (eq_out !== 16'h0) $display("FAIL abort_eq_out got %h want 0000", eq_out); else pass_cnt++;
    for (int c = 0; c < 10; c++) begin
      if (eq_valid) seen++;
      @(negedge clk);
    end
    total_cnt++; if (seen !== 0) $display("FAIL abort_no_valid got %0d pulses want 0", seen); else pass_cnt++;
    for (int b = 0; b < NB; b++) begin
      m_aud[b] = pick_audio();
      m_pot[b] = pick_pot();
    end
    exp_v = ref_eq();
    apply_strobe();
    wait_result(lat);
    total_cnt++; if (lat !== LAT) $display("FAIL abort_fresh_latency got %0d want %0d", lat, LAT); else pass_cnt++;
    total_cnt++; if (eq_out !== 16'(exp_v)) $display("FAIL abort_fresh_out got %h want %h", eq_out, 16'(exp_v)); else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    int exp_v;
    for (int b = 0; b < NB; b++) begin
      m_aud[b] = pick_audio();
      m_pot[b] = pick_pot();
    end
    exp_v = ref_eq();
    apply_strobe();
    for (int s = 0; s < 16; s++) begin
      wait_result(lat);
      total_cnt++;
      if (lat !== LAT) $display("FAIL b2b%0d_latency got %0d want %0d", s, lat, LAT); else pass_cnt++;
      total_cnt++;
      if (eq_out !== 16'(exp_v)) $display("FAIL b2b%0d_eq_out got %h want %h", s, eq_out, 16'(exp_v));
      else pass_cnt++;
      if (s < 15) begin
        for (int b = 0; b < NB; b++) begin
          m_aud[b] = pick_audio();
          m_pot[b] = pick_pot();
        end
        exp_v = ref_eq();
        apply_strobe();
      end
    end
    @(negedge clk);
    total_cnt++; if (overrun !== 1'b0) $display("FAIL b2b_overrun got %b want 0", overrun); else pass_cnt++;
  endtask

  initial begin
    rst_n      = 1'b0;
    smpl_valid = 1'b0;
    ovr_clr    = 1'b0;
    band_audio = '0;
    band_pot   = '0;
    test_reset();
    test_single_band();
    test_patterns();
    test_overrun();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
